// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: access sizes and
// the response routing register values.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles fetch lost to data; only built
// when MEM_ARB_FAIRNESS_EN is defined.
module arb_starve_counter #(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !starved) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Full-rate arbiter sharing one memory port between fetch and load/store.
// Optional fetch anti-starvation is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  // Handshake: a request is held until its gnt is seen in the same cycle;
  // a granted read returns one rvalid pulse in the following cycle.
  resp_owner_t resp_owner, resp_owner_nxt;
  logic        fetch_forced;

`ifdef MEM_ARB_FAIRNESS_EN
  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (if_req & d_gnt),
    .clr     (if_gnt | ~if_req),
    .starved (fetch_forced)
  );
`else
  assign fetch_forced = 1'b0;
`endif

  // Data normally wins (older instruction); a starved fetch takes the contended cycle.
  assign d_gnt    = ~rst & d_req & ~(if_req & fetch_forced);
  assign if_gnt   = ~rst & if_req & (~d_req | fetch_forced);
  assign stall_if = if_req & ~if_gnt;

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_size       = 2'b00;
    mem_signed     = 1'b0;
    resp_owner_nxt = OWN_NONE;
    if (d_gnt) begin
      mem_read   = ~d_we;
      mem_write  = d_we;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
      mem_size   = d_size;
      mem_signed = d_signed;
      if (!d_we) resp_owner_nxt = OWN_D;
    end else if (if_gnt) begin
      mem_read       = 1'b1;
      mem_addr       = if_addr;
      mem_size       = SIZE_WORD;
      resp_owner_nxt = OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner <= OWN_NONE;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      if (resp_owner_nxt == OWN_IF) if_rdata <= mem_rdata;
      if (resp_owner_nxt == OWN_D)  d_rdata  <= mem_rdata;
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign d_rvalid  = (resp_owner == OWN_D);

endmodule
